// File: rtl/avalon_pio_pkg.sv
// Shared definitions for the avalon_pio_out output port: register map,
// address width and the per-bit pulse timer state encoding.
package avalon_pio_pkg;

    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA        = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_SET         = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_CLEAR       = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_TOGGLE      = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_PULSE_LEN   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_PULSE_START = 3'd5;

    typedef enum logic {
        IDLE    = 1'b0,
        PULSING = 1'b1
    } timer_state_e;

endpackage

// File: rtl/avalon_pio_out_pulse_timer.sv
// Single-bit pulse timer: loads a length on start, counts down, and flags
// expiry on the cycle its counter reads 1. Cancel forces it back to IDLE.
module pio_pulse_timer
    import avalon_pio_pkg::*;
#(
    parameter int unsigned PULSE_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cancel,
    input  logic [PULSE_W-1:0] len,
    output logic               busy,
    output logic               expire
);

    timer_state_e       state_q, state_d;
    logic [PULSE_W-1:0] cnt_q, cnt_d;

    // Next-state: cancel beats start, start (re)arms, otherwise count down.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cancel) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (start && (len != '0)) begin
            state_d = PULSING;
            cnt_d   = len;
        end else if (state_q == PULSING) begin
            if (cnt_q == PULSE_W'(1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - PULSE_W'(1);
            end
        end
    end

    // Timer state and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy   = (state_q == PULSING);
    assign expire = (state_q == PULSING) && (cnt_q == PULSE_W'(1));

endmodule

// File: rtl/avalon_pio_out.sv
// Avalon-MM output port with atomic set/clear/toggle and optional per-bit
// timed pulses. Define AVALON_PIO_PULSE_EN to build PULSE_LEN, PULSE_START
// and the timers; otherwise addresses 4-5 are reserved.
module avalon_pio_out
    import avalon_pio_pkg::*;
#(
    parameter int unsigned      WIDTH             = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE       = '0,
    parameter int unsigned      PULSE_W           = 16,
    parameter int unsigned      DEFAULT_PULSE_LEN = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] cpu_mask, cpu_val;
    logic [WIDTH-1:0] busy, expire, start_vec;
    logic             unused_bits;

    assign wr = chipselect && !write_n;
    assign wd = writedata[WIDTH-1:0];

`ifdef AVALON_PIO_PULSE_EN
    logic [PULSE_W-1:0] pulse_len_q, pulse_len_d;

    assign start_vec = (wr && (address == ADDR_PULSE_START) && (pulse_len_q != '0)) ? wd : '0;

    // PULSE_LEN register; running timers keep the length they were armed with.
    always_comb begin
        pulse_len_d = pulse_len_q;
        if (wr && (address == ADDR_PULSE_LEN))
            pulse_len_d = writedata[PULSE_W-1:0];
    end

    // PULSE_LEN storage.
    always_ff @(posedge clk) begin
        if (reset) pulse_len_q <= PULSE_W'(DEFAULT_PULSE_LEN);
        else       pulse_len_q <= pulse_len_d;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_timer
        pio_pulse_timer #(.PULSE_W(PULSE_W)) u_timer (
            .clk    (clk),
            .reset  (reset),
            .start  (start_vec[i]),
            .cancel (cpu_mask[i]),
            .len    (pulse_len_q),
            .busy   (busy[i]),
            .expire (expire[i])
        );
    end
    assign unused_bits = ^writedata;
`else
    assign start_vec   = '0;
    assign busy        = '0;
    assign expire      = '0;
    assign unused_bits = (^writedata) ^ (PULSE_W == 0) ^ (DEFAULT_PULSE_LEN == 0) ^ (^busy);
`endif

    // CPU write mask and value; masked bits override any timer activity.
    always_comb begin
        cpu_mask = '0;
        cpu_val  = '0;
        if (wr) begin
            case (address)
                ADDR_DATA:   begin cpu_mask = '1; cpu_val = wd;      end
                ADDR_SET:    begin cpu_mask = wd; cpu_val = '1;      end
                ADDR_CLEAR:  begin cpu_mask = wd; cpu_val = '0;      end
                ADDR_TOGGLE: begin cpu_mask = wd; cpu_val = ~data_q; end
                default:     ;
            endcase
        end
    end

    // Output value: expiry clears, pulse start sets, CPU write has final say.
    always_comb begin
        data_d = (data_q & ~expire) | start_vec;
        data_d = (data_d & ~cpu_mask) | (cpu_val & cpu_mask);
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (reset) data_q <= RESET_VALUE;
        else       data_q <= data_d;
    end

    // Zero-latency read mux on the current address.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLEAR, ADDR_TOGGLE: readdata = 32'(data_q);
`ifdef AVALON_PIO_PULSE_EN
            ADDR_PULSE_LEN:   readdata = 32'(pulse_len_q);
            ADDR_PULSE_START: readdata = 32'(busy);
`endif
            default: readdata = '0;
        endcase
    end

    assign out_port = data_q;

endmodule
